// File: rtl/bram_burst_master.sv
// Burst master for a single 32-bit BRAM port: accepts write/read burst commands,
// streams write data straight to the BRAM and returns read data through a 2-entry skid FIFO.
`timescale 1ns/1ps
module bram_burst_master #(
    parameter int C_PORT_DWIDTH = 32,
    parameter int C_PORT_AWIDTH = 32,
    parameter int C_NUM_WE      = 4,
    parameter int C_MEMSIZE     = 'h10000
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Cmd_Valid,
    output logic                     Cmd_Ready,
    input  logic                     Cmd_Write,
    input  logic [0:C_PORT_AWIDTH-1] Cmd_Addr,
    input  logic [0:8]               Cmd_Len,
    input  logic                     Wr_Valid,
    output logic                     Wr_Ready,
    input  logic [0:C_PORT_DWIDTH-1] Wr_Data,
    input  logic [0:C_NUM_WE-1]      Wr_BE,
    output logic                     Rd_Valid,
    input  logic                     Rd_Ready,
    output logic [0:C_PORT_DWIDTH-1] Rd_Data,
    output logic                     Done,
    output logic                     Err,
    output logic                     BRAM_Clk_A,
    output logic                     BRAM_Rst_A,
    output logic                     BRAM_EN_A,
    output logic [0:C_NUM_WE-1]      BRAM_WEN_A,
    output logic [0:C_PORT_AWIDTH-1] BRAM_Addr_A,
    output logic [0:C_PORT_DWIDTH-1] BRAM_Dout_A,
    input  logic [0:C_PORT_DWIDTH-1] BRAM_Din_A
);

    localparam int AW = C_PORT_AWIDTH;
    localparam int DW = C_PORT_DWIDTH;
    localparam logic [AW-1:0] OFFSET_MASK = AW'(C_MEMSIZE - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t          state;
    logic [8:0]      remaining;
    logic [AW-1:0]   addr;
    logic            in_flight;
    logic [DW-1:0]   fifo_mem [2];
    logic            fifo_wr_ptr;
    logic            fifo_rd_ptr;
    logic [1:0]      fifo_count;

    logic [AW-1:0]   cmd_addr;
    logic [8:0]      cmd_len;
    logic            cmd_accept;
    logic            cmd_bad;
    logic            wr_issue;
    logic            rd_issue;
    logic            pop;
    logic [1:0]      pending;
    logic [AW-1:0]   addr_next;

    always_comb begin
        cmd_addr   = Cmd_Addr;
        cmd_len    = Cmd_Len;
        cmd_accept = Cmd_Valid && Cmd_Ready && (state == IDLE);
        cmd_bad    = (cmd_len == 9'd0) || (cmd_len > 9'd256) || (cmd_addr[1:0] != 2'b00);
        pop        = (fifo_count != 2'd0) && Rd_Ready;
        // Occupancy seen by the issue logic already discounts this cycle's pop,
        // which is what sustains one word per clock with Rd_Ready held high.
        pending    = {1'b0, in_flight} + fifo_count - {1'b0, pop};
        wr_issue   = Wr_Valid && Wr_Ready;
        rd_issue   = (state == READ) && (remaining != 9'd0) && (pending < 2'd2);
        addr_next  = (addr & ~OFFSET_MASK) | ((addr + AW'(4)) & OFFSET_MASK);
    end

    assign Wr_Ready    = (state == WRITE) && (remaining != 9'd0);
    assign BRAM_EN_A   = wr_issue || rd_issue;
    assign BRAM_WEN_A  = wr_issue ? Wr_BE : '0;
    assign BRAM_Dout_A = wr_issue ? Wr_Data : '0;
    assign BRAM_Addr_A = addr;
    assign BRAM_Clk_A  = Clk;
    assign BRAM_Rst_A  = Rst;
    assign Rd_Valid    = (fifo_count != 2'd0);
    assign Rd_Data     = fifo_mem[fifo_rd_ptr];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            Cmd_Ready <= 1'b1;
            Done      <= 1'b0;
            Err       <= 1'b0;
            remaining <= '0;
            addr      <= '0;
            in_flight <= 1'b0;
        end else begin
            Done      <= 1'b0;
            Err       <= 1'b0;
            in_flight <= rd_issue;
            if (wr_issue || rd_issue) begin
                addr      <= addr_next;
                remaining <= remaining - 9'd1;
            end
            case (state)
                IDLE: begin
                    if (cmd_accept) begin
                        Cmd_Ready <= 1'b0;
                        if (cmd_bad) begin
                            state <= DONE;
                            Done  <= 1'b1;
                            Err   <= 1'b1;
                        end else begin
                            addr      <= cmd_addr;
                            remaining <= cmd_len;
                            state     <= Cmd_Write ? WRITE : READ;
                        end
                    end
                end
                WRITE: begin
                    if (wr_issue && (remaining == 9'd1)) begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end
                end
                READ: begin
                    if (remaining == 9'd0) state <= DRAIN;
                end
                DRAIN: begin
                    if (!in_flight && (fifo_count == 2'd0)) begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    Cmd_Ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    Cmd_Ready <= 1'b1;
                end
            endcase
        end
    end

    // Read data lands one cycle after its issue; capture it then.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_count  <= '0;
        end else begin
            if (in_flight) begin
                fifo_mem[fifo_wr_ptr] <= BRAM_Din_A;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (pop) fifo_rd_ptr <= ~fifo_rd_ptr;
            fifo_count <= fifo_count + {1'b0, in_flight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_bram_burst_master.sv
// Randomized directed bench for bram_burst_master: a BRAM model answers the port and a
// word-array reference model predicts every access, read word and completion.
`timescale 1ns/1ps
module tb_bram_burst_master;

    localparam logic [31:0] MEMSIZE = 32'h10000;
    localparam logic [31:0] MASK    = MEMSIZE - 32'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [0:31] cmd_addr;
    logic [0:8]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [0:31] wr_data;
    logic [0:3]  wr_be;
    logic        rd_valid, rd_ready;
    logic [0:31] rd_data;
    logic        done, err;
    logic        bram_clk, bram_rst, bram_en;
    logic [0:3]  bram_wen;
    logic [0:31] bram_addr, bram_dout, bram_din;

    always #5 clk = ~clk;

    bram_burst_master #(
        .C_PORT_DWIDTH(32),
        .C_PORT_AWIDTH(32),
        .C_NUM_WE(4),
        .C_MEMSIZE(32'h10000)
    ) dut (
        .Clk(clk), .Rst(rst),
        .Cmd_Valid(cmd_valid), .Cmd_Ready(cmd_ready), .Cmd_Write(cmd_write),
        .Cmd_Addr(cmd_addr), .Cmd_Len(cmd_len),
        .Wr_Valid(wr_valid), .Wr_Ready(wr_ready), .Wr_Data(wr_data), .Wr_BE(wr_be),
        .Rd_Valid(rd_valid), .Rd_Ready(rd_ready), .Rd_Data(rd_data),
        .Done(done), .Err(err),
        .BRAM_Clk_A(bram_clk), .BRAM_Rst_A(bram_rst), .BRAM_EN_A(bram_en),
        .BRAM_WEN_A(bram_wen), .BRAM_Addr_A(bram_addr), .BRAM_Dout_A(bram_dout),
        .BRAM_Din_A(bram_din)
    );

    typedef struct { logic [31:0] addr; logic [3:0] wen; logic [31:0] dout; int cyc; } acc_t;
    typedef struct { logic [31:0] data; int cyc; } rd_t;
    typedef struct { logic err; int cyc; } dn_t;

    acc_t        acc_q[$];
    rd_t         rd_q[$];
    dn_t         done_q[$];
    int          cyc = 0;
    int          issued = 0, popped = 0, max_out = 0;
    logic [31:0] mem     [16384];
    logic [31:0] ref_mem [16384];
    logic [31:0] next_din;
    int          checks = 0, errors = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        bram_din <= next_din;
    end

    // Mid-cycle observer and BRAM model: logs accesses, pops and Done; reads return next cycle.
    always @(negedge clk) begin
        logic [31:0] a, d;
        logic [3:0]  w;
        a = bram_addr;
        d = bram_dout;
        w = bram_wen;
        if (rst) begin
            issued = 0;
            popped = 0;
        end
        if (issued - popped > max_out) max_out = issued - popped;
        next_din = 'x;
        if (bram_en) begin
            acc_q.push_back('{a, w, d, cyc});
            if (w == 4'h0) begin
                next_din = mem[a[15:2]];
                issued++;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (w[b]) mem[a[15:2]][8*b +: 8] = d[8*b +: 8];
            end
        end
        if (rd_valid && rd_ready) begin
            rd_q.push_back('{32'(rd_data), cyc});
            popped++;
        end
        if (done) done_q.push_back('{err, cyc});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wrap(input logic [31:0] base, input int i);
        return (base & ~MASK) | ((base + 32'(4 * i)) & MASK);
    endfunction

    task automatic check_reset(input string tag);
        check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, ".wr_ready"},  32'(wr_ready),  32'd0);
        check({tag, ".rd_valid"},  32'(rd_valid),  32'd0);
        check({tag, ".done"},      32'(done),      32'd0);
        check({tag, ".err"},       32'(err),       32'd0);
        check({tag, ".en"},        32'(bram_en),   32'd0);
        check({tag, ".wen"},       32'(bram_wen),  32'd0);
        check({tag, ".addr"},      32'(bram_addr), 32'd0);
        check({tag, ".dout"},      32'(bram_dout), 32'd0);
        check({tag, ".rd_data"},   32'(rd_data),   32'd0);
        check({tag, ".bram_rst"},  32'(bram_rst),  32'd1);
    endtask

    // One command end to end. rr_mode: 0 ready always, 1 pattern 1,0,0, 2 random.
    task automatic burst(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [8:0] len, input int wv_mode, input int rr_mode,
                         input logic [31:0] dat_base);
        logic [31:0] wdat [256];
        logic [3:0]  wbe  [256];
        logic        exp_err;
        logic [31:0] a;
        int ab, rb, db, acc_cyc, idx, nacc, nrd, n, rr_ph, exp_n;
        exp_err = (len == 9'd0) || (len > 9'd256) || (addr[1:0] != 2'b00);
        for (int i = 0; i < 256; i++) begin
            wdat[i] = (dat_base != 32'd0) ? dat_base + 32'(i) : $urandom;
            wbe[i]  = (wv_mode != 0) ? 4'($urandom_range(1, 15)) : 4'hF;
        end
        ab = acc_q.size();
        rb = rd_q.size();
        db = done_q.size();
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        wr_valid  = 1'b0;
        rd_ready  = 1'b0;
        check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        acc_cyc = cyc;
        idx = 0;
        n = 0;
        rr_ph = 0;
        while (done_q.size() == db && n < 40 + 12 * int'(len)) begin
            @(posedge clk); #1;
            n++;
            cmd_valid = 1'b0;
            cmd_write = ~wr;
            cmd_addr  = $urandom;
            cmd_len   = 9'($urandom);
            if (wr && idx < int'(len)) begin
                wr_valid = (wv_mode == 0) || ($urandom_range(0, 3) != 0);
                wr_data  = wdat[idx];
                wr_be    = wbe[idx];
            end else begin
                wr_valid = 1'b0;
                wr_data  = $urandom;
                wr_be    = 4'($urandom);
            end
            rd_ready = (rr_mode == 0) ? 1'b1 :
                       (rr_mode == 1) ? (rr_ph % 3 == 0) : 1'($urandom_range(0, 1));
            rr_ph++;
            if (wr_valid && wr_ready) idx++;
        end
        wr_valid = 1'b0;
        check({tag, ".done_count"}, 32'(done_q.size() - db), 32'd1);
        check({tag, ".cmd_ready_after"}, 32'(cmd_ready), 32'd1);
        nacc = acc_q.size() - ab;
        nrd  = rd_q.size() - rb;
        if (done_q.size() > db) begin
            check({tag, ".err"}, 32'(done_q[db].err), 32'(exp_err));
            if (exp_err)
                check({tag, ".done_cyc"}, 32'(done_q[db].cyc), 32'(acc_cyc + 1));
            else if (wr && nacc > 0)
                check({tag, ".done_cyc"}, 32'(done_q[db].cyc), 32'(acc_q[ab + nacc - 1].cyc + 1));
            else if (!wr && nrd > 0)
                check({tag, ".done_after_data"}, 32'(done_q[db].cyc > rd_q[rb + nrd - 1].cyc), 32'd1);
        end
        exp_n = exp_err ? 0 : int'(len);
        check({tag, ".n_access"}, 32'(nacc), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            a = wrap(addr, i);
            if (wr)
                for (int b = 0; b < 4; b++)
                    if (wbe[i][b]) ref_mem[a[15:2]][8*b +: 8] = wdat[i][8*b +: 8];
            if (i < nacc) begin
                check({tag, ".addr"}, acc_q[ab + i].addr, a);
                check({tag, ".wen"}, 32'(acc_q[ab + i].wen), wr ? 32'(wbe[i]) : 32'd0);
                if (wr) check({tag, ".dout"}, acc_q[ab + i].dout, wdat[i]);
                if ((wr && wv_mode == 0) || (!wr && rr_mode == 0))
                    check({tag, ".issue_cyc"}, 32'(acc_q[ab + i].cyc), 32'(acc_cyc + 1 + i));
            end
            if (!wr && i < nrd) begin
                check({tag, ".rd_data"}, rd_q[rb + i].data, ref_mem[a[15:2]]);
                // accept edge, issue cycle, BRAM latency cycle, then FIFO head
                if (rr_mode == 0)
                    check({tag, ".rd_cyc"}, 32'(rd_q[rb + i].cyc), 32'(acc_cyc + 3 + i));
            end
        end
        check({tag, ".n_read"}, 32'(nrd), (!wr && !exp_err) ? 32'(len) : 32'd0);
        check({tag, ".max_outstanding"}, 32'(max_out <= 2), 32'd1);
        rd_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ab, db, n;
        logic [31:0] ra;
        int rl;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; wr_be = '0; rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        check("bram_clk", 32'(bram_clk), 32'(clk));
        rst = 1'b0;

        burst("w100", 1'b1, 32'h100, 9'd4, 0, 0, 32'hA0);
        burst("r100", 1'b0, 32'h100, 9'd4, 0, 0, 32'h0);
        burst("w200", 1'b1, 32'h200, 9'd8, 1, 0, 32'h0);
        burst("r200_toggle", 1'b0, 32'h200, 9'd8, 0, 1, 32'h0);
        burst("w_wrap", 1'b1, 32'hFFF8, 9'd4, 0, 0, 32'h0);
        burst("r_wrap", 1'b0, 32'hFFF8, 9'd4, 0, 2, 32'h0);
        burst("e_len0", 1'b0, 32'h100, 9'd0, 0, 0, 32'h0);
        burst("e_unal", 1'b1, 32'h102, 9'd4, 0, 0, 32'h0);
        burst("e_len300", 1'b1, 32'h300, 9'd300, 0, 0, 32'h0);
        burst("e_unal_rd", 1'b0, 32'h101, 9'd2, 0, 0, 32'h0);
        burst("w_long", 1'b1, 32'h1234_4000, 9'd256, 1, 0, 32'h0);
        burst("r_long", 1'b0, 32'h1234_4000, 9'd256, 0, 1, 32'h0);

        for (int k = 0; k < 6; k++) begin
            ra = $urandom & 32'hFFFF_FFFC;
            rl = $urandom_range(1, 24);
            burst("w_rand", 1'b1, ra, 9'(rl), 1, 0, 32'h0);
            burst("r_rand", 1'b0, ra, 9'(rl), 0, 2, 32'h0);
        end

        ab = acc_q.size();
        db = done_q.size();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h100; cmd_len = 9'd8; rd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (acc_q.size() - ab < 3 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        check("rst.third_issue", 32'(acc_q.size() - ab), 32'd3);
        rst = 1'b1;
        #1;
        check_reset("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst_hold");
        check("rst.no_done", 32'(done_q.size() - db), 32'd0);
        rst = 1'b0;
        rd_ready = 1'b0;
        burst("post_rst_rd", 1'b0, 32'h100, 9'd4, 0, 0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
